// File: rtl/display_pkg.sv
// Shared types and constants for the WS2812 segment display path.
package display_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, LATCH} ws_state_t;

  localparam int          GRB_WIDTH = 24;
  localparam logic [23:0] COLOR_RED = 24'h00FF00;  // GRB order: green, red, blue
  localparam logic [23:0] COLOR_OFF = 24'h000000;

endpackage

// File: rtl/ws2812_symbol_timer.sv
// Generates one WS2812 symbol per go pulse: a high phase of T1H_CYC or T0H_CYC cycles,
// then low until BIT_CYC cycles have elapsed. A go on the sym_done cycle chains symbols seamlessly.
module ws2812_symbol_timer #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic sym_done
);

  localparam int CW = $clog2(BIT_CYC);

  logic [CW-1:0] cnt;
  logic [CW-1:0] thr;
  logic          active;

  // cnt holds the cycles still to run after the current one; dout stays high while cnt > thr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      thr    <= '0;
      active <= 1'b0;
      dout   <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      cnt    <= CW'(BIT_CYC - 1);
      thr    <= bit_val ? CW'(BIT_CYC - T1H_CYC) : CW'(BIT_CYC - T0H_CYC);
      dout   <= 1'b1;
    end else if (active) begin
      if (cnt != '0) begin
        cnt  <= cnt - 1'b1;
        dout <= (cnt > thr);
      end else begin
        active <= 1'b0;
        dout   <= 1'b0;
      end
    end
  end

  assign sym_done = active && (cnt == '0);

endmodule

// File: rtl/ws2812_segment_driver.sv
// Pulls segment bits from upstream, expands each to a GRB word and drives the WS2812 line,
// closing every frame with a latch low period.
module ws2812_segment_driver
  import display_pkg::*;
#(
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int RESET_CYC = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  led_count,
  input  logic [23:0] on_color,
  output logic        bit_req,
  input  logic        bit_in,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  localparam int LW = $clog2(RESET_CYC + 1);

  ws_state_t              state;
  logic [5:0]             led_cnt;
  logic [GRB_WIDTH-1:0]   color_q;
  logic [GRB_WIDTH-1:0]   shreg;
  logic [4:0]             sym_idx;
  logic [LW-1:0]          lat_cnt;
  logic                   go;
  logic                   bit_val;
  logic                   sym_done;

  // The first symbol starts straight out of WAIT, so its value bypasses shreg
  always_comb begin
    go      = (state == WAIT) || ((state == SEND) && sym_done && (sym_idx != 5'd23));
    bit_val = (state == WAIT) ? (bit_in & color_q[GRB_WIDTH-1]) : shreg[GRB_WIDTH-2];
  end

  ws2812_symbol_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_symbol_timer (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .bit_val  (bit_val),
    .dout     (dout),
    .sym_done (sym_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      led_cnt <= '0;
      color_q <= '0;
      shreg   <= '0;
      sym_idx <= '0;
      lat_cnt <= '0;
      bit_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      bit_req <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          // done is still high in the first IDLE cycle; a start there is dropped
          if (start && !done) begin
            led_cnt <= led_count;
            color_q <= on_color;
            busy    <= 1'b1;
            if (led_count != 6'd0) begin
              state   <= FETCH;
              bit_req <= 1'b1;
            end else begin
              state   <= LATCH;
              lat_cnt <= LW'(RESET_CYC - 1);
            end
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          shreg   <= bit_in ? color_q : COLOR_OFF;
          sym_idx <= '0;
          state   <= SEND;
        end
        SEND: begin
          if (sym_done) begin
            if (sym_idx == 5'd23) begin
              led_cnt <= led_cnt - 6'd1;
              if (led_cnt == 6'd1) begin
                state   <= LATCH;
                lat_cnt <= LW'(RESET_CYC - 1);
              end else begin
                state   <= FETCH;
                bit_req <= 1'b1;
              end
            end else begin
              shreg   <= {shreg[GRB_WIDTH-2:0], 1'b0};
              sym_idx <= sym_idx + 5'd1;
            end
          end
        end
        LATCH: begin
          if (lat_cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
